// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - single-outstanding instruction fetcher feeding a DEPTH-entry decode queue.
// Optional FETCH_STALL_CNT_EN adds a saturating decode-starvation counter (stall_count).
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
`ifdef FETCH_STALL_CNT_EN
  input  logic [31:0] redirect_pc,
  output logic [31:0] stall_count
`else
  input  logic [31:0] redirect_pc
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic          req_next;
  logic [31:0]   addr_next;
  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic          push, pop;
  logic [31:0]   redirect_aligned;

  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  // Responses are only accepted while our own request is live; a redirect discards them.
  assign push      = (state == REQ) && imem_ack && !redirect_valid;
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? mem_pc[head]    : 32'h0;
  assign out_instr = out_valid ? mem_instr[head] : 32'h0;

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_next      = imem_req;
    addr_next     = imem_addr;
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_next = redirect_aligned;
        end else if (count < FULL) begin
          state_next = REQ;
          req_next   = 1'b1;
          addr_next  = fetch_pc;
        end
      end
      REQ: begin
        if (imem_ack) begin
          fetch_pc_next = fetch_pc + 32'd4;
          state_next    = IDLE;
          req_next      = 1'b0;
        end
        // Without a coincident ack the request stays on the bus until memory answers.
        if (redirect_valid) begin
          fetch_pc_next = redirect_aligned;
          state_next    = imem_ack ? IDLE : DROP;
        end
      end
      DROP: begin
        if (redirect_valid) fetch_pc_next = redirect_aligned;
        if (imem_ack) begin
          state_next = IDLE;
          req_next   = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_next;
      fetch_pc  <= fetch_pc_next;
      imem_req  <= req_next;
      imem_addr <= addr_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[tail]    <= fetch_pc;
      mem_instr[tail] <= imem_rdata;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= 32'h0;
    end else if (out_ready && !out_valid && !redirect_valid && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed self-checking bench for instr_fetch_queue.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  int checks   = 0;
  int failures = 0;
  int lat      = 1;
  int age      = 0;
  bit mem_on   = 1'b1;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid),
`ifdef FETCH_STALL_CNT_EN
    .redirect_pc(redirect_pc),
    .stall_count(stall_count)
`else
    .redirect_pc(redirect_pc)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge and memory answers after lat request cycles.
  task automatic step();
    @(posedge clk);
    #1;
    if (imem_req && mem_on) begin
      age++;
      if (age >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_addr ^ KEY;
        age        = 0;
      end else begin
        imem_ack = 1'b0;
      end
    end else begin
      imem_ack = 1'b0;
      age      = 0;
    end
  endtask

  task automatic do_reset(input int latency, input logic ready);
    reset          = 1'b1;
    imem_ack       = 1'b0;
    imem_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = ready;
    lat            = latency;
    age            = 0;
    mem_on         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_pc", out_pc, 32'h0);
`ifdef FETCH_STALL_CNT_EN
    check("rst_stall", stall_count, 32'h0);
`endif
    reset = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [31:0] exp_pc);
    for (int i = 0; i < 40; i++) begin
      if (out_valid) break;
      step();
    end
    check({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
    check({tag, "_pc"}, out_pc, exp_pc);
    check({tag, "_instr"}, out_instr, exp_pc ^ KEY);
  endtask

  task automatic wait_req(input logic [31:0] addr);
    for (int i = 0; i < 40; i++) begin
      if (imem_req && imem_addr == addr) break;
      step();
    end
    check("wait_req", imem_addr, addr);
  endtask

  initial begin
    reset = 1'b1;

    // In-order stream with 1-cycle memory latency
    do_reset(1, 1'b1);
    wait_out("s0", 32'h0);  step();
    wait_out("s4", 32'h4);  step();
    wait_out("s8", 32'h8);  step();
    wait_out("sC", 32'hC);  step();

    // Back-pressure: queue fills to DEPTH and fetch stops
    do_reset(1, 1'b0);
    repeat (14) step();
    check("full_req", {31'h0, imem_req}, 32'h0);
    check("full_valid", {31'h0, out_valid}, 32'h1);
    check("full_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    wait_out("bp0", 32'h0);   step();
    wait_out("bp4", 32'h4);   step();
    wait_out("bp8", 32'h8);   step();
    wait_out("bpC", 32'hC);   step();
    wait_out("bp10", 32'h10); step();

    // Simultaneous push and pop with three stored entries
    do_reset(1, 1'b0);
    wait_req(32'hC);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pp_pc", out_pc, 32'h4);
    repeat (10) step();
    check("pp_full_req", {31'h0, imem_req}, 32'h0);
    out_ready = 1'b1;
    check("pp_h0", out_pc, 32'h4);  step();
    check("pp_h1", out_pc, 32'h8);  step();
    check("pp_h2", out_pc, 32'hC);  step();
    check("pp_h3", out_pc, 32'h10); step();
    out_ready = 1'b0;

    // Redirect while request at 0x8 is outstanding; stale data dropped
    do_reset(4, 1'b1);
    wait_req(32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h104;
    step();
    redirect_valid = 1'b0;
    check("drop_valid", {31'h0, out_valid}, 32'h0);
    check("drop_req", {31'h0, imem_req}, 32'h1);
    check("drop_addr", imem_addr, 32'h8);
    wait_out("rd104", 32'h104);

    // Redirect coincident with ack: response discarded, go straight to IDLE
    do_reset(1, 1'b1);
    wait_req(32'h4);
    check("co_ack", {31'h0, imem_ack}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    check("co_valid", {31'h0, out_valid}, 32'h0);
    check("co_req", {31'h0, imem_req}, 32'h0);
    wait_out("co40", 32'h40);

    // Redirect on a full queue flushes it; unaligned target is aligned and fetch_pc wraps
    do_reset(1, 1'b0);
    repeat (12) step();
    check("fl_valid_pre", {31'h0, out_valid}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    check("fl_valid", {31'h0, out_valid}, 32'h0);
    out_ready = 1'b1;
    wait_out("wrapFC", 32'hFFFF_FFFC); step();
    wait_out("wrap0", 32'h0);          step();

    // Reset mid-request; an ack right after release is ignored
    do_reset(3, 1'b1);
    wait_req(32'h0);
    reset = 1'b1;
    #1;
    check("mr_req", {31'h0, imem_req}, 32'h0);
    check("mr_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    mem_on     = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    mem_on = 1'b1;
    age    = 0;
    check("mr_valid_post", {31'h0, out_valid}, 32'h0);
    check("mr_req_post", {31'h0, imem_req}, 32'h1);
    wait_out("mr0", 32'h0);

`ifdef FETCH_STALL_CNT_EN
    do_reset(2, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      step();
    end
    check("stall_valid", {31'h0, out_valid}, 32'h1);
    check("stall_cnt", stall_count, 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
